// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // CLEAR: post-reset zeroing pass; RUN: normal read/write operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Register-number width for a file of nreg registers (nreg >= 2).
  function automatic int rf_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// Per-read-port forwarding selector: finds the highest-index enabled write
// port whose destination matches the read address.
module regfile_fwd_sel
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = rf_aw(NREG_DEF),
  parameter int NWR  = 1
) (
  input  logic [AW-1:0]       rs_num_i,
  input  logic [NWR*AW-1:0]   rd_num_i,
  input  logic [NWR*XLEN-1:0] rd_val_i,
  input  logic [NWR-1:0]      reg_write_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     data_o
);

  // Ascending scan so the last (highest-index) matching port wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = 0; j < NWR; j++) begin
      if (reg_write_i[j] && (rd_num_i[j*AW +: AW] == rs_num_i)) begin
        hit_o  = 1'b1;
        data_o = rd_val_i[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, same-cycle write-to-read
// forwarding, and a sequential post-reset clear pass gated by ready_o.
//
// Handshake: ready_o is a level. While it is low the file is clearing, writes
// are dropped and enabled reads return 0. Once high it stays high until rst.
// Reads have one cycle of latency; a disabled read port holds its output.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN = XLEN_DEF,
  parameter int  NREG = NREG_DEF,
  parameter int  NRD  = 2,
  parameter int  NWR  = 1,
  localparam int AW   = rf_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rsNum_i,
  input  logic [NRD-1:0]      rsEn_i,
  output logic [NRD*XLEN-1:0] rsVal_o,
  input  logic [NWR*AW-1:0]   rdNum_i,
  input  logic [NWR*XLEN-1:0] rdVal_i,
  input  logic [NWR-1:0]      regWrite_i,
  output logic                ready_o
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  rf_state_e           state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [NRD*XLEN-1:0] rs_val_q, rs_val_d;

  // x0 has no storage; entries 1..NREG-1 only.
  logic [XLEN-1:0] rf_q [1:NREG-1];
  logic [XLEN-1:0] rf_d [1:NREG-1];

  logic [NRD-1:0]      fwd_hit;
  logic [NRD*XLEN-1:0] fwd_data;

  // One forwarding selector per read port.
  for (genvar i = 0; i < NRD; i++) begin : g_fwd
    regfile_fwd_sel #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_sel (
      .rs_num_i    (rsNum_i[i*AW +: AW]),
      .rd_num_i    (rdNum_i),
      .rd_val_i    (rdVal_i),
      .reg_write_i (regWrite_i),
      .hit_o       (fwd_hit[i]),
      .data_o      (fwd_data[i*XLEN +: XLEN])
    );
  end

  // State, clear counter, ready flag and read outputs; rst restarts the pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= AW'(1);
      ready_q   <= 1'b0;
      rs_val_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      rs_val_q  <= rs_val_d;
    end
  end

  // Array contents are left untouched during the rst cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_q <= rf_d;
    end
  end

  // Next state: walk clr_cnt up to the last register, then enter RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    if (state_q == CLEAR) begin
      if (clr_cnt_q == LAST_REG) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end
  end

  // Array update and read-port data for each state.
  always_comb begin
    rf_d     = rf_q;
    rs_val_d = rs_val_q;
    if (state_q == CLEAR) begin
      rf_d[clr_cnt_q] = '0;
      for (int i = 0; i < NRD; i++) begin
        if (rsEn_i[i]) rs_val_d[i*XLEN +: XLEN] = '0;
      end
    end else begin
      // Reads see pre-edge contents unless an enabled write forwards.
      for (int i = 0; i < NRD; i++) begin
        if (rsEn_i[i]) begin
          if (rsNum_i[i*AW +: AW] == '0) begin
            rs_val_d[i*XLEN +: XLEN] = '0;
          end else if (fwd_hit[i]) begin
            rs_val_d[i*XLEN +: XLEN] = fwd_data[i*XLEN +: XLEN];
          end else begin
            rs_val_d[i*XLEN +: XLEN] = rf_q[rsNum_i[i*AW +: AW]];
          end
        end
      end
      // Ascending order: the highest-index port targeting a register wins.
      for (int j = 0; j < NWR; j++) begin
        if (regWrite_i[j] && (rdNum_i[j*AW +: AW] != '0)) begin
          rf_d[rdNum_i[j*AW +: AW]] = rdVal_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  assign rsVal_o = rs_val_q;
  assign ready_o = ready_q;

endmodule
